ysyx_23060337_ifu: RTL
======================

Name: ysyx_23060337_ifu

Overview:
- Instruction fetch unit. Supplies 32-bit instruction words and their PC to the decode stage.
- Owns the PC register and issues word fetches on a valid/ready memory request channel; the memory returns data on a response channel.
- Holds each fetched word until decode accepts it, then advances the PC by 4.
- Accepts PC redirects from execute (branch/jump) and discards any stale in-flight response.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, address/data width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  out  1  fetch request valid.
- req_ready  in  1  memory accepts the request this cycle.
- req_addr  out  32  fetch address, word aligned.
- resp_valid  in  1  response data valid; exactly one response per accepted request, in order.
- resp_data  in  32  fetched instruction word.
- inst_valid  out  1  inst/pc valid to decode.
- inst_ready  in  1  decode accepts inst this cycle.
- inst  out  32  instruction word.
- pc  out  32  address of inst.
- redirect_valid  in  1  one-cycle redirect request.
- redirect_pc  in  32  redirect target.
- misalign  out  1  one-cycle pulse: the accepted redirect had redirect_pc[1:0] != 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=REQ, fetch_pc=RESET_PC, drop=0, inst=0, pc=0.
  - req_valid=0, inst_valid=0, misalign=0 while rst_n is low.
  - The first request is presented in the first cycle after rst_n deasserts.
  - Reset asserted mid-transaction abandons that transaction; memory must discard it.
- req_valid is 1 only in state REQ. req_addr = {fetch_pc[31:2],2'b00}. Both are driven from registers with no combinational path from any input.
- States and transitions (redirect overrides everything below it):
  - REQ: hold req_valid/req_addr stable until req_ready. On req_ready -> WAIT.
  - WAIT: on resp_valid, either
    - drop=0: inst<=resp_data, pc<=fetch_pc, -> HOLD; or
    - drop=1: discard the data, clear drop, -> REQ.
  - HOLD: inst_valid=1; inst and pc are stable. On inst_ready: fetch_pc<=fetch_pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), -> REQ.
- Minimum latency: request accepted in cycle N, response in N+1, inst_valid visible in N+2. Best-case throughput is one instruction per 3 cycles; no prefetch.
- Redirect (redirect_valid=1), by state:
  - All states: fetch_pc<=redirect_pc & ~32'h3. Registered misalign pulses in the next cycle if redirect_pc[1:0] != 0.
  - REQ, req_ready=0: request withdrawn; stay in REQ with the new address next cycle.
  - REQ, req_ready=1 in the same cycle: the old request is in flight. drop<=1, -> WAIT.
  - WAIT, resp_valid=0: drop<=1, stay in WAIT.
  - WAIT, resp_valid=1 in the same cycle: discard the response, -> REQ.
  - HOLD: inst_valid deasserts next cycle, -> REQ. A simultaneous inst_ready still consumes the current instruction, but no +4 is applied; the redirect target wins.
- Repeated redirects before the drop response arrives keep drop=1. The last target wins, and only one response is discarded.
- resp_valid in REQ or HOLD is a protocol violation. It is ignored; the bench asserts it never happens.

Test Plan:
- Reset, req_ready=1, single-cycle memory returning 32'h00000413, inst_ready=1: req_addr=80000000, then 80000004, 80000008. inst_valid every 3rd cycle with pc matching each address.
- Backpressure: hold inst_ready=0 for 5 cycles in HOLD. inst/pc stay stable, req_valid stays 0, no PC advance. Release -> next req_addr=pc+4.
- Redirect in WAIT to 80001000 with response 2 cycles later. Response discarded, no inst_valid for it. Next req_addr=80001000, and that fetch is delivered with pc=80001000.
- Redirect in the same cycle as req_ready, target 80000203. Stale response dropped, misalign pulses once. Next req_addr=80000200.
- Redirect in HOLD with inst_ready=1 together, target 80002000. Next request is 80002000, not pc+4.
- Assert rst_n low in the middle of WAIT, then release. Outputs go to reset values at once. First req_addr=80000000 and drop=0.

Source files
------------

// File: rtl/ysyx_23060337_ifu.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time on a
// valid/ready request channel, holds the returned word for decode, and
// handles redirects by discarding at most one stale in-flight response.
//
// Handshake rules:
//   - A channel transfer happens on a rising edge where valid and ready are
//     both 1.
//   - While valid is 1 and ready is 0, the producer holds valid and its
//     payload stable. The only exception is a redirect, which withdraws
//     the pending request or instruction.
//   - Memory returns exactly one resp_valid pulse per accepted request, in
//     order.
`timescale 1ns/1ps
module ysyx_23060337_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic            drop;
  logic            req_fire;
  logic [XLEN-1:0] redirect_aligned;
  logic            redirect_misaligned;

  assign req_fire            = req_valid & req_ready;
  assign redirect_aligned    = {redirect_pc[XLEN-1:2], 2'b00};
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

  // Address is a pure function of the PC register, so it has no input path.
  assign req_addr = {fetch_pc[XLEN-1:2], 2'b00};

  // Fetch FSM. req_valid/inst_valid are registered copies of "next state is
  // REQ/HOLD", so both are 0 during reset. The first request therefore
  // appears on the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_REQ;
      fetch_pc   <= RESET_PC;
      drop       <= 1'b0;
      inst       <= '0;
      pc         <= '0;
      req_valid  <= 1'b0;
      inst_valid <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      misalign <= redirect_valid & redirect_misaligned;
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
      end
      case (state)
        S_REQ: begin
          if (req_fire) begin
            // A redirect in the accept cycle leaves the old request in
            // flight, so its response must be thrown away.
            drop      <= redirect_valid;
            state     <= S_WAIT;
            req_valid <= 1'b0;
          end else begin
            req_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (resp_valid) begin
            if (drop || redirect_valid) begin
              drop      <= 1'b0;
              state     <= S_REQ;
              req_valid <= 1'b1;
            end else begin
              inst       <= resp_data;
              pc         <= fetch_pc;
              state      <= S_HOLD;
              inst_valid <= 1'b1;
            end
          end else if (redirect_valid) begin
            // Further redirects keep drop set; only one response is pending.
            drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            // Redirect target wins over sequential +4, even if consumed.
            state      <= S_REQ;
            inst_valid <= 1'b0;
            req_valid  <= 1'b1;
          end else if (inst_ready) begin
            fetch_pc   <= fetch_pc + XLEN'(4);
            state      <= S_REQ;
            inst_valid <= 1'b0;
            req_valid  <= 1'b1;
          end
        end
        default: begin
          state      <= S_REQ;
          req_valid  <= 1'b1;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
